// File: rtl/sys_timer_pkg.sv
// Shared widths, register map and CTRL bit positions for the system timer.
package sys_timer_pkg;

  localparam int MEM_W      = 32;
  localparam int MEM_ADDR_W = 32;

  localparam logic [3:0] ADDR_CTRL  = 4'h0;
  localparam logic [3:0] ADDR_PRESC = 4'h4;
  localparam logic [3:0] ADDR_CNT   = 4'h8;
  localparam logic [3:0] ADDR_CMP   = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_AR   = 2;
  localparam int CTRL_PEND = 3;

  function automatic logic [MEM_W-1:0] byte_merge(input logic [MEM_W-1:0] cur,
                                                  input logic [MEM_W-1:0] wdat,
                                                  input logic [3:0]       strb);
    logic [MEM_W-1:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdat[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_timer_if.sv
// Reduced AXI4-lite slave channel set (AW/W/AR/R, no B) between interconnect and timer.
interface sys_timer_if;
  import sys_timer_pkg::*;

  logic [MEM_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [MEM_W-1:0]      wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [MEM_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [MEM_W-1:0]      rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
    input  awready, wready, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
    output awready, wready, arready, rdata, rvalid
  );

endinterface

// File: rtl/sys_timer_core.sv
// Prescaler, 32-bit up-counter, compare and sticky PEND flag.
// Updates every cycle; bus writes take priority over tick updates, match-set over W1C.
module sys_timer_core
  import sys_timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               ar,
  input  logic [PRESC_W-1:0] presc,
  input  logic               presc_wr,
  input  logic [MEM_W-1:0]   cmp,
  input  logic               cnt_we,
  input  logic [3:0]         cnt_wstrb,
  input  logic [MEM_W-1:0]   cnt_wdat,
  input  logic               pend_clr,
  output logic [MEM_W-1:0]   cnt,
  output logic               pend
);

  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic               match;

  assign tick  = en && (pcnt == presc);
  assign match = tick && (cnt == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!en || presc_wr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_we) begin
      cnt <= byte_merge(cnt, cnt_wdat, cnt_wstrb);
    end else if (tick) begin
      cnt <= (match && ar) ? '0 : cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (match) begin
      pend <= 1'b1;
    end else if (pend_clr) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped system timer: AXI4-lite slave FSMs and register decode around sys_timer_core.
// Write: 2 cycles valids->readies->update; read: arready N+1, rvalid N+2 held until rready.
module sys_timer
  import sys_timer_pkg::*;
#(
  parameter int               PRESC_W = 16,
  parameter logic [MEM_W-1:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  sys_timer_if.slave  timer_axi,
  output logic        timer_irq
);

  localparam logic       W_IDLE = 1'b0;
  localparam logic       W_ACK  = 1'b1;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic               w_state;
  logic [3:0]         w_addr;
  logic [MEM_W-1:0]   w_dat;
  logic [3:0]         w_strb;
  logic [1:0]         r_state;
  logic [3:0]         r_addr;

  logic               en, ie, ar;
  logic [PRESC_W-1:0] presc;
  logic [MEM_W-1:0]   cmp;
  logic [MEM_W-1:0]   cnt;
  logic               pend;
  logic [MEM_W-1:0]   rd_val;

  logic               wr_fire;
  logic               wr_ctrl, wr_presc, wr_cnt, wr_cmp;
  logic               pend_clr;
  logic               unused_addr;

  assign unused_addr = ^{timer_axi.awaddr[MEM_ADDR_W-1:4], timer_axi.awaddr[1:0],
                         timer_axi.araddr[MEM_ADDR_W-1:4], timer_axi.araddr[1:0]};

  // AW and W are only ever taken together, so a lone AW never gets a ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_dat   <= '0;
      w_strb  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (timer_axi.awvalid && timer_axi.wvalid) begin
            w_state <= W_ACK;
            w_addr  <= {timer_axi.awaddr[3:2], 2'b00};
            w_dat   <= timer_axi.wdata;
            w_strb  <= timer_axi.wstrb;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign timer_axi.awready = (w_state == W_ACK);
  assign timer_axi.wready  = (w_state == W_ACK);

  assign wr_fire  = (w_state == W_ACK);
  assign wr_ctrl  = wr_fire && (w_addr == ADDR_CTRL);
  assign wr_presc = wr_fire && (w_addr == ADDR_PRESC);
  assign wr_cnt   = wr_fire && (w_addr == ADDR_CNT);
  assign wr_cmp   = wr_fire && (w_addr == ADDR_CMP);
  assign pend_clr = wr_ctrl && w_strb[0] && w_dat[CTRL_PEND];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      ar        <= 1'b0;
      presc     <= '0;
      cmp       <= CMP_RST;
      timer_irq <= 1'b0;
    end else begin
      if (wr_ctrl && w_strb[0]) begin
        en <= w_dat[CTRL_EN];
        ie <= w_dat[CTRL_IE];
        ar <= w_dat[CTRL_AR];
      end
      if (wr_presc) begin
        for (int i = 0; i < PRESC_W; i++) begin
          if (w_strb[i/8]) presc[i] <= w_dat[i];
        end
      end
      if (wr_cmp) cmp <= byte_merge(cmp, w_dat, w_strb);
      timer_irq <= pend && ie;
    end
  end

  sys_timer_core #(
    .PRESC_W (PRESC_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ar        (ar),
    .presc     (presc),
    .presc_wr  (wr_presc),
    .cmp       (cmp),
    .cnt_we    (wr_cnt),
    .cnt_wstrb (w_strb),
    .cnt_wdat  (w_dat),
    .pend_clr  (pend_clr),
    .cnt       (cnt),
    .pend      (pend)
  );

  always_comb begin
    rd_val = '0;
    case (r_addr)
      ADDR_CTRL: begin
        rd_val[CTRL_EN]   = en;
        rd_val[CTRL_IE]   = ie;
        rd_val[CTRL_AR]   = ar;
        rd_val[CTRL_PEND] = pend;
      end
      ADDR_PRESC: rd_val = MEM_W'(presc);
      ADDR_CNT:   rd_val = cnt;
      ADDR_CMP:   rd_val = cmp;
      default:    rd_val = '0;
    endcase
  end

  // rdata is captured once at the end of R_ADDR and held for the whole R_DATA phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= R_IDLE;
      r_addr          <= '0;
      timer_axi.rdata <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (timer_axi.arvalid) begin
            r_state <= R_ADDR;
            r_addr  <= {timer_axi.araddr[3:2], 2'b00};
          end
        end
        R_ADDR: begin
          r_state         <= R_DATA;
          timer_axi.rdata <= rd_val;
        end
        R_DATA: begin
          if (timer_axi.rready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign timer_axi.arready = (r_state == R_ADDR);
  assign timer_axi.rvalid  = (r_state == R_DATA);

endmodule

// File: doc/sys_timer.md
# sys_timer

Memory-mapped 32-bit system timer that answers on the AXI4-lite responder side of the SoC interconnect, occupying a free slave slot (s3). It accepts register reads and writes through the reduced slave channel set the interconnect drives (AW/W/AR/R; no B channel), and runs a prescaled up-counter. A compare match raises a level interrupt toward the core's external trap input.

## Interface
Parameters:
- PRESC_W, 16, prescaler register width (bits [PRESC_W-1:0] of PRESC are implemented)
- CMP_RST, 32'hFFFF_FFFF, reset value of CMP

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- timer_axi_awaddr  in  `MemAddrBus  write address; only [3:2] decoded
- timer_axi_awvalid  in  1  write address valid
- timer_axi_awready  out  1  write address accept
- timer_axi_wdata  in  `MemBus  write data
- timer_axi_wstrb  in  4  byte enables
- timer_axi_wvalid  in  1  write data valid
- timer_axi_wready  out  1  write data accept
- timer_axi_araddr  in  `MemAddrBus  read address; only [3:2] decoded
- timer_axi_arvalid  in  1  read address valid
- timer_axi_arready  out  1  read address accept
- timer_axi_rdata  out  `MemBus  read data
- timer_axi_rvalid  out  1  read data valid
- timer_axi_rready  in  1  read data accept
- timer_irq  out  1  level interrupt = CTRL.PEND & CTRL.IE

## Operation
- Registers (offset: fields, reset): 0x0 CTRL: [0] EN, [1] IE, [2] AR (clear CNT on match), [3] PEND (W1C), others read 0, reset 0. 0x4 PRESC: [PRESC_W-1:0], reset 0. 0x8 CNT: 32-bit, R/W, reset 0. 0xC CMP: 32-bit, R/W, reset CMP_RST.
- All writes honour wstrb per byte; PEND bit written only when wstrb[0]=1 and wdata[3]=1 (clears).
- Prescaler: internal pcnt. EN=0: pcnt held at 0, CNT frozen. EN=1: pcnt increments; when pcnt==PRESC, pcnt<=0 and a tick fires. PRESC=0 gives a tick every cycle.
- On tick: if CNT==CMP, PEND<=1 and CNT<=(AR ? 0 : CNT+1); else CNT<=CNT+1 (wraps 0xFFFF_FFFF->0).
- Write to PRESC resets pcnt to 0.
- Write channel: FSM W_IDLE -> W_ACK when awvalid&wvalid both high; W_ACK asserts awready=wready=1 for exactly one cycle, register updated at that edge, then W_IDLE. Never accepts AW without W.
- Read channel: FSM R_IDLE -> R_ADDR (arready=1 one cycle, address latched) -> R_DATA (rvalid=1, rdata stable) -> R_IDLE on rready. arready low while in R_DATA.
- Read and write channels independent; may complete in same cycle.
- Collisions: bus write to CNT beats tick update same cycle; PEND set by match beats W1C same cycle.

## Timing
- Reset: awready, wready, arready, rvalid, timer_irq = 0; rdata = 0; FSMs idle; pcnt = 0.
- Write: valids seen cycle N -> readies high N+1 -> register value visible N+2.
- Read: arvalid cycle N -> arready N+1 -> rvalid/rdata N+2; held until rready sampled high. Back-to-back read: next arready no earlier than cycle after rvalid drops.
- Read data is the register value sampled at the R_ADDR edge.
- timer_irq registered: high the cycle after PEND becomes 1.
- Reset mid-transaction: all handshake outputs drop asynchronously; partial transfer discarded.

## Structure
- Register offsets (0x0/0x4/0x8/0xC) and CTRL bit indices added to defines.v.
- One sub-module natural: sys_timer_core (prescaler, counter, compare, PEND); AXI FSMs and register decode stay in sys_timer.

## Test plan
- Reset: after rst_n release, read 0x8 -> 0, 0xC -> 0xFFFF_FFFF, 0x0 -> 0; timer_irq=0.
- Write CMP=5, PRESC=0, CTRL=0x7 -> PEND set on 6th tick, timer_irq high next cycle, CNT returns to 0 and repeats every 6 ticks.
- PRESC=3, EN=1 -> CNT increments once per 4 cycles; read CNT 40 cycles after enable -> 10 (±1 per latency rule).
- Write 0x8 (CNT) with wstrb=4'b0010, wdata=0x0000_AB00 on CNT=0x12 -> CNT=0x0000_AB12; write coinciding with a tick wins.
- Hold rready low 10 cycles on a read -> rvalid and rdata stable throughout, arready stays 0; concurrent write completes in 2 cycles.
- W1C PEND same cycle as new match -> PEND stays 1; W1C alone -> timer_irq falls.
